// File: rtl/joystick_direction_filter.sv
// Deadzone classifier and debouncer for multi-bit X/Y joystick samples; keeps the 2-bit direction code.
// Define JOYSTICK_AUTOREPEAT_EN to add auto-repeat dir_event pulses while a direction stays committed.
module joystick_direction_filter #(
    parameter int AXIS_W        = 8,
    parameter int DEADZONE      = 32,
    parameter int STABLE_CYCLES = 16,
    parameter int REPEAT_DELAY  = 1000000,
    parameter int REPEAT_PERIOD = 250000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AXIS_W-1:0] x_axis,
    input  logic [AXIS_W-1:0] y_axis,
    output logic [1:0]        direction,
    output logic              dir_valid,
    output logic              dir_event
);

    localparam logic [1:0] DIR_DOWN  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_UP    = 2'b11;

    localparam logic [AXIS_W:0] CENTER = {2'b01, {(AXIS_W-1){1'b0}}};
    localparam logic [AXIS_W:0] DZ     = DEADZONE[AXIS_W:0];

    localparam int              CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_e;

    // Elaboration-time guards on illegal parameter combinations.
    if (AXIS_W < 2 || AXIS_W > 16) begin : g_bad_axis_w
        $error("joystick_direction_filter: AXIS_W must be in 2..16");
    end
    if (DEADZONE < 0 || DEADZONE >= (1 << (AXIS_W - 1))) begin : g_bad_deadzone
        $error("joystick_direction_filter: DEADZONE must be below the centre value");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("joystick_direction_filter: STABLE_CYCLES must be at least 1");
    end
    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
        $error("joystick_direction_filter: REPEAT_DELAY and REPEAT_PERIOD must be at least 2");
    end

    function automatic logic [AXIS_W:0] magnitude(input logic signed [AXIS_W:0] d);
        return d[AXIS_W] ? $unsigned(-d) : $unsigned(d);
    endfunction

    // Stage 1: input registers
    logic [AXIS_W-1:0] x_q, x_d;
    logic [AXIS_W-1:0] y_q, y_d;

    // Classification
    logic signed [AXIS_W:0] dx, dy;
    logic                   x_act, y_act;
    logic                   raw_active;
    logic [1:0]             raw_dir;

    // Debounce
    logic             cand_active_q, cand_active_d;
    logic [1:0]       cand_dir_q, cand_dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cand_match;
    logic             commit;

    // Committed state
    state_e     state_q, state_d;
    logic [1:0] direction_q, direction_d;
    logic       dir_event_q, dir_event_d;

`ifdef JOYSTICK_AUTOREPEAT_EN
    localparam int               RPT_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int               RPT_W       = $clog2(RPT_MAX);
    localparam logic [RPT_W-1:0] RPT_DLY_LD  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PER_LD  = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

    always_comb begin
        x_d = x_axis;
        y_d = y_axis;
    end

    // The extra sign bit keeps 0 and all-ones from wrapping around the centre.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        raw_active = 1'b0;
        raw_dir    = DIR_DOWN;
        dx         = $signed({1'b0, x_q}) - $signed(CENTER);
        dy         = $signed({1'b0, y_q}) - $signed(CENTER);
        x_act      = magnitude(dx) > DZ;
        y_act      = magnitude(dy) > DZ;
        if (x_act) begin
            raw_active = 1'b1;
            raw_dir    = dx[AXIS_W] ? DIR_LEFT : DIR_RIGHT;
        end else if (y_act) begin
            raw_active = 1'b1;
            raw_dir    = dy[AXIS_W] ? DIR_DOWN : DIR_UP;
        end
    end

    // A candidate commits only once it has matched raw for STABLE_CYCLES-1 further edges.
    always_comb begin
        cand_active_d = cand_active_q;
        cand_dir_d    = cand_dir_q;
        cnt_d         = cnt_q;
        cand_match    = (cand_active_q == raw_active) && (cand_dir_q == raw_dir);
        commit        = cand_match && (cnt_q == CNT_MAX) &&
                        ({cand_active_q, cand_dir_q} != {dir_valid, direction_q});
        if (!cand_match) begin
            cand_active_d = raw_active;
            cand_dir_d    = raw_dir;
            cnt_d         = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        direction_d = direction_q;
        dir_event_d = 1'b0;
`ifdef JOYSTICK_AUTOREPEAT_EN
        rpt_cnt_d   = rpt_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef JOYSTICK_AUTOREPEAT_EN
                rpt_cnt_d = '0;
`endif
                if (commit && cand_active_q) begin
                    state_d     = S_ACTIVE;
                    direction_d = cand_dir_q;
                    dir_event_d = 1'b1;
`ifdef JOYSTICK_AUTOREPEAT_EN
                    rpt_cnt_d   = RPT_DLY_LD;
`endif
                end
            end
            S_ACTIVE: begin
                if (commit) begin
                    if (cand_active_q) begin
                        direction_d = cand_dir_q;
                        dir_event_d = 1'b1;
`ifdef JOYSTICK_AUTOREPEAT_EN
                        rpt_cnt_d   = RPT_DLY_LD;
`endif
                    end else begin
                        state_d     = S_IDLE;
                        direction_d = DIR_DOWN;
`ifdef JOYSTICK_AUTOREPEAT_EN
                        rpt_cnt_d   = '0;
`endif
                    end
                end
`ifdef JOYSTICK_AUTOREPEAT_EN
                else if (rpt_cnt_q == '0) begin
                    dir_event_d = 1'b1;
                    rpt_cnt_d   = RPT_PER_LD;
                end else begin
                    rpt_cnt_d = rpt_cnt_q - 1'b1;
                end
`endif
            end
            default: begin
                state_d     = S_IDLE;
                direction_d = DIR_DOWN;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q           <= '0;
            y_q           <= '0;
            cand_active_q <= 1'b0;
            cand_dir_q    <= DIR_DOWN;
            cnt_q         <= '0;
            state_q       <= S_IDLE;
            direction_q   <= DIR_DOWN;
            dir_event_q   <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            cand_active_q <= cand_active_d;
            cand_dir_q    <= cand_dir_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            direction_q   <= direction_d;
            dir_event_q   <= dir_event_d;
        end
    end

`ifdef JOYSTICK_AUTOREPEAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`endif

    assign direction = direction_q;
    assign dir_valid = (state_q == S_ACTIVE);
    assign dir_event = dir_event_q;

endmodule

// File: tb/tb_joystick_direction_filter.sv
// Scoreboard bench: a sliding-window reference model predicts outputs; a monitor compares them.
module tb_joystick_direction_filter;

    localparam int AXIS_W = 8;
    localparam int DZ     = 32;
    localparam int SC     = 4;
    localparam int RD     = 10;
    localparam int RP     = 5;
    localparam int CENTER = 128;

`ifdef JOYSTICK_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam int C_NONE  = 0;
    localparam int C_RIGHT = 1;
    localparam int C_LEFT  = 2;
    localparam int C_UP    = 3;
    localparam int C_DOWN  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [AXIS_W-1:0] x_in, y_in;
    logic [1:0]        direction;
    logic              dir_valid;
    logic              dir_event;

    always #5 clk = ~clk;

    joystick_direction_filter #(
        .AXIS_W        (AXIS_W),
        .DEADZONE      (DZ),
        .STABLE_CYCLES (SC),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .x_axis    (x_in),
        .y_axis    (y_in),
        .direction (direction),
        .dir_valid (dir_valid),
        .dir_event (dir_event)
    );

    typedef struct {
        int         cyc;
        logic [1:0] dir;
        logic       valid;
        logic       evt;
    } level_t;

    typedef struct {
        int         cyc;
        logic [1:0] dir;
    } event_t;

    level_t lvl_q[$];
    event_t evt_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int classify(input int x, input int y);
        int dx = x - CENTER;
        int dy = y - CENTER;
        int ax = (dx < 0) ? -dx : dx;
        int ay = (dy < 0) ? -dy : dy;
        if (ax > DZ) return (dx > 0) ? C_RIGHT : C_LEFT;
        if (ay > DZ) return (dy > 0) ? C_UP : C_DOWN;
        return C_NONE;
    endfunction

    function automatic logic [1:0] code_dir(input int c);
        case (c)
            C_RIGHT: return 2'b01;
            C_LEFT:  return 2'b10;
            C_UP:    return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Reference model: a classification commits once the last SC+1 sampled classifications agree
    // and differ from what is committed; a reset edge counts as a "none" sample.
    initial begin
        int hist[$];
        int xq_m = 0;
        int yq_m = 0;
        int committed = C_NONE;
        int next_rpt = 0;
        forever begin
            int  raw;
            bit  stable;
            bit  evt;
            @(posedge clk);
            cyc++;
            evt = 1'b0;
            if (reset) begin
                xq_m = 0;
                yq_m = 0;
                hist.delete();
                hist.push_back(C_NONE);
                committed = C_NONE;
            end else begin
                raw = classify(xq_m, yq_m);
                hist.push_back(raw);
                if (hist.size() > SC + 1) void'(hist.pop_front());
                stable = (hist.size() == SC + 1);
                foreach (hist[i]) if (hist[i] != raw) stable = 1'b0;
                if (stable && raw != committed) begin
                    committed = raw;
                    if (raw != C_NONE) begin
                        evt      = 1'b1;
                        next_rpt = cyc + RD;
                    end
                end else if (AUTO && committed != C_NONE && cyc == next_rpt) begin
                    evt      = 1'b1;
                    next_rpt = cyc + RP;
                end
                xq_m = int'(x_in);
                yq_m = int'(y_in);
            end
            lvl_q.push_back('{cyc, code_dir(committed), committed != C_NONE, evt});
            if (evt) evt_q.push_back('{cyc, code_dir(committed)});
        end
    end

    // Monitor: samples on the falling edge, pops expected levels every cycle and events on dir_event.
    initial begin
        logic prev_evt = 1'b0;
        @(posedge clk);
        forever begin
            level_t l;
            event_t e;
            @(negedge clk);
            check("level_record_present", lvl_q.size() != 0, 1);
            if (lvl_q.size() != 0) begin
                l = lvl_q.pop_front();
                check("direction", direction, l.dir);
                check("dir_valid", dir_valid, l.valid);
                check("dir_event", dir_event, l.evt);
            end
            if (dir_event) begin
                check("no_back_to_back_event", prev_evt, 0);
                check("event_expected", evt_q.size() != 0, 1);
                if (evt_q.size() != 0) begin
                    e = evt_q.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("event_direction", direction, e.dir);
                end
            end
            prev_evt = dir_event;
        end
    end

    task automatic hold(input int x, input int y, input int n);
        x_in = AXIS_W'(x);
        y_in = AXIS_W'(y);
        repeat (n) @(negedge clk);
    endtask

    function automatic int pick_axis();
        case ($urandom_range(0, 7))
            0:       return int'($urandom_range(0, 255));
            1:       return 95 + int'($urandom_range(0, 1));
            2:       return 160 + int'($urandom_range(0, 1));
            3:       return 0;
            4:       return 255;
            default: return CENTER;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        x_in  = 8'd200;
        y_in  = 8'd200;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        hold(200, 200, 10);
        hold(128, 128, 10);
        // Deadzone boundary: |dx| == 32 stays centred, 33 commits.
        hold(160, 128, 20);
        hold(161, 128, 10);
        hold(95, 128, 10);
        hold(128, 128, 10);
        // Short glitches: 3 and 4 sampled cycles must not commit, 5 must.
        hold(200, 128, 3);
        hold(128, 128, 10);
        hold(200, 128, 4);
        hold(128, 128, 10);
        hold(200, 128, 5);
        hold(128, 128, 10);
        // X priority, then Y up/down and release.
        hold(40, 250, 10);
        hold(128, 250, 10);
        hold(128, 0, 10);
        hold(128, 128, 10);
        // Reset mid-debounce.
        hold(200, 128, 2);
        reset = 1'b1;
        hold(200, 128, 1);
        reset = 1'b0;
        hold(200, 128, 12);
        // Extremes and direct right-to-left swap.
        hold(255, 128, 8);
        hold(0, 128, 8);
        hold(128, 255, 8);
        hold(128, 0, 8);
        hold(128, 128, 10);
        hold(200, 128, 40);
        hold(128, 128, 10);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                hold(pick_axis(), pick_axis(), int'($urandom_range(1, 2)));
                reset = 1'b0;
            end
            hold(pick_axis(), pick_axis(), int'($urandom_range(1, 8)));
        end
        hold(128, 128, 12);
        @(negedge clk);
        #1;
        check("event_queue_drained", evt_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
